load_burst_sequencer: RTL and testbench

LOAD_BURST_SEQUENCER -- requirements
Module: load_burst_sequencer

---
 rtl/vlsu_pkg.sv | 17 +
 rtl/load_burst_sequencer_if.sv | 58 +++++
 rtl/burst_size_calc.sv | 51 +++++
 rtl/load_burst_sequencer.sv | 129 ++++++++++++
 tb/tb_load_burst_sequencer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vlsu_pkg.sv
// Shared definitions for the load burst sequencer.
//   seq_state_e : sequencer FSM states
//   PAGE_BYTES  : AXI 4 KiB boundary that no burst may cross
//   PAGE_OFF_W  : number of address bits inside one page
package vlsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam int unsigned PAGE_BYTES = 4096;
    localparam int unsigned PAGE_OFF_W = $clog2(PAGE_BYTES);

endpackage

// File: rtl/load_burst_sequencer_if.sv
// Handshake bundle between the load burst sequencer and its environment.
//   req_*  : load request in (start address, byte count)
//   ar_*   : AXI read-address issue
//   txn_*  : per-burst control to the load unit
//   r_last : one pulse per R handshake carrying last
//   done_* : request-complete response
// modport master is the sequencer side, modport slave the environment side.
interface load_burst_sequencer_if #(
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned BytesWidth   = 32
);
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [AxiAddrWidth-1:0] req_addr_i;
    logic [BytesWidth-1:0]   req_bytes_i;

    logic                    ar_valid_o;
    logic                    ar_ready_i;
    logic [AxiAddrWidth-1:0] ar_addr_o;
    logic [7:0]              ar_len_o;
    logic [2:0]              ar_size_o;

    logic                    txn_valid_o;
    logic                    txn_ready_i;
    logic [AxiAddrWidth-1:0] txn_addr_o;
    logic [12:0]             txn_bytes_o;
    logic                    txn_last_o;

    logic                    r_last_i;

    logic                    done_valid_o;
    logic                    done_ready_i;

    modport master (
        input  req_valid_i, req_addr_i, req_bytes_i,
        output req_ready_o,
        output ar_valid_o, ar_addr_o, ar_len_o, ar_size_o,
        input  ar_ready_i,
        output txn_valid_o, txn_addr_o, txn_bytes_o, txn_last_o,
        input  txn_ready_i,
        input  r_last_i,
        output done_valid_o,
        input  done_ready_i
    );

    modport slave (
        output req_valid_i, req_addr_i, req_bytes_i,
        input  req_ready_o,
        input  ar_valid_o, ar_addr_o, ar_len_o, ar_size_o,
        output ar_ready_i,
        input  txn_valid_o, txn_addr_o, txn_bytes_o, txn_last_o,
        output txn_ready_i,
        output r_last_i,
        input  done_valid_o,
        output done_ready_i
    );

endinterface

// File: rtl/burst_size_calc.sv
// Combinational size of the next burst from the current position.
//   page_off_i  : cur_addr[11:0]
//   rem_bytes_i : bytes still to request
//   bytes_o     : min(rem, bytes to page end, 256 beats minus start offset)
//   len_o       : AXI len = beats touched - 1
//   last_o      : this burst finishes the request
// Requires a beat of at least 2 bytes.
module burst_size_calc
    import vlsu_pkg::*;
#(
    parameter int unsigned AxiDataWidth = 256,
    parameter int unsigned BytesWidth   = 32
) (
    input  logic [PAGE_OFF_W-1:0] page_off_i,
    input  logic [BytesWidth-1:0] rem_bytes_i,
    output logic [12:0]           bytes_o,
    output logic [7:0]            len_o,
    output logic                  last_o
);

    localparam int unsigned BeatBytes = AxiDataWidth / 8;
    localparam int unsigned OffW      = $clog2(BeatBytes);
    // Wide enough for the byte count, 4096 and 256 beats without overflow.
    localparam int unsigned CW        = BytesWidth + OffW + 14;

    function automatic logic [CW-1:0] umin(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    logic [CW-1:0] rem_w;
    logic [CW-1:0] page_w;
    logic [CW-1:0] beat_off_w;
    logic [CW-1:0] burst_w;
    logic [CW-1:0] bytes_w;
    logic [CW-1:0] span_w;

    always_comb begin
        rem_w      = CW'(rem_bytes_i);
        page_w     = CW'(PAGE_BYTES) - CW'(page_off_i);
        beat_off_w = CW'(page_off_i[OffW-1:0]);
        burst_w    = CW'(BeatBytes * 256) - beat_off_w;
        bytes_w    = umin(rem_w, umin(page_w, burst_w));
        // An unaligned start widens the beat span by the leading offset.
        span_w     = beat_off_w + bytes_w + CW'(BeatBytes - 1);
    end

    assign bytes_o = 13'(bytes_w);
    assign len_o   = 8'((span_w >> OffW) - CW'(1));
    assign last_o  = (bytes_w == rem_w);

endmodule

// File: rtl/load_burst_sequencer.sv
// Splits a load request (address, byte count) into AXI read bursts that
// never cross a 4 KiB page and never exceed 256 beats, issuing each burst
// on AR and on the load-unit control channel in the same cycle.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (master)  : req / ar / txn / r_last / done handshakes
// At most MaxOutstanding bursts are in flight; the request completes once
// every burst has returned its last R beat.
module load_burst_sequencer
    import vlsu_pkg::*;
#(
    parameter int unsigned AxiAddrWidth   = 64,
    parameter int unsigned AxiDataWidth   = 256,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned BytesWidth     = 32
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    load_burst_sequencer_if.master bus
);

    localparam int unsigned OffW = $clog2(AxiDataWidth / 8);
    localparam int unsigned OW   = $clog2(MaxOutstanding + 1);
    localparam logic [OW-1:0] MaxOut = OW'(MaxOutstanding);

    seq_state_e              state_q, state_d;
    logic [OW-1:0]           outstanding_q;
    logic [AxiAddrWidth-1:0] cur_addr_q;
    logic [BytesWidth-1:0]   rem_bytes_q;

    logic [12:0]             burst_bytes;
    logic [7:0]              burst_len;
    logic                    burst_last;
    logic                    issue_ok;
    logic                    fire;
    logic                    accept;

    burst_size_calc #(
        .AxiDataWidth (AxiDataWidth),
        .BytesWidth   (BytesWidth)
    ) u_calc (
        .page_off_i  (cur_addr_q[PAGE_OFF_W-1:0]),
        .rem_bytes_i (rem_bytes_q),
        .bytes_o     (burst_bytes),
        .len_o       (burst_len),
        .last_o      (burst_last)
    );

    // Valids decode registered state only, so payloads (also from
    // registers) cannot move until the burst fires.
    assign issue_ok = (state_q == ST_ISSUE) && (outstanding_q < MaxOut);
    assign fire     = issue_ok && bus.ar_ready_i && bus.txn_ready_i;
    assign accept   = (state_q == ST_IDLE) && bus.req_valid_i;

    assign bus.req_ready_o  = (state_q == ST_IDLE);
    assign bus.ar_valid_o   = issue_ok;
    assign bus.txn_valid_o  = issue_ok;
    assign bus.done_valid_o = (state_q == ST_DONE);
    assign bus.ar_addr_o    = cur_addr_q;
    assign bus.ar_len_o     = burst_len;
    assign bus.ar_size_o    = 3'(OffW);
    assign bus.txn_addr_o   = cur_addr_q;
    assign bus.txn_bytes_o  = burst_bytes;
    assign bus.txn_last_o   = burst_last;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    state_d = (bus.req_bytes_i == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (fire && burst_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.done_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_addr_q  <= '0;
            rem_bytes_q <= '0;
        end else if (accept) begin
            cur_addr_q  <= bus.req_addr_i;
            rem_bytes_q <= bus.req_bytes_i;
        end else if (fire) begin
            cur_addr_q  <= cur_addr_q + AxiAddrWidth'(burst_bytes);
            rem_bytes_q <= rem_bytes_q - BytesWidth'(burst_bytes);
        end
    end

    // Fire and r_last in the same cycle cancel out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else if (fire && !bus.r_last_i) begin
            outstanding_q <= outstanding_q + OW'(1);
        end else if (!fire && bus.r_last_i) begin
            outstanding_q <= outstanding_q - OW'(1);
        end
    end

    r_last_needs_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        bus.r_last_i |-> (outstanding_q != '0)
    );

endmodule

// File: tb/tb_load_burst_sequencer.sv
module tb_load_burst_sequencer;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned DATA_W  = 256;
    localparam int unsigned MAX_OUT = 2;
    localparam int unsigned BYTES_W = 32;
    localparam longint unsigned BEAT = DATA_W / 8;
    localparam longint unsigned SIZE = 5;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [12:0] bytes;
        logic        last;
    } burst_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_burst_sequencer_if #(.AxiAddrWidth(ADDR_W), .BytesWidth(BYTES_W)) bus ();

    load_burst_sequencer #(
        .AxiAddrWidth   (ADDR_W),
        .AxiDataWidth   (DATA_W),
        .MaxOutstanding (MAX_OUT),
        .BytesWidth     (BYTES_W)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;

    burst_t stage_q[$];
    burst_t exp_q[$];
    int     tokens = 0;
    int     model_out = 0;
    int     fire_cnt = 0;
    int     ready_mode = 0;
    bit     rlast_en = 1'b1;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a burst ends at the earliest of request end, page end or
    // the 256th beat; len is the count of beat slots touched minus one.
    function automatic void model_bursts(input longint unsigned a, input longint unsigned n);
        longint unsigned cur = a;
        longint unsigned stop = a + n;
        longint unsigned page_end, beat_end, end_b;
        burst_t e;
        while (cur < stop) begin
            page_end = (cur / 4096 + 1) * 4096;
            beat_end = (cur / BEAT + 256) * BEAT;
            end_b = stop;
            if (page_end < end_b) end_b = page_end;
            if (beat_end < end_b) end_b = beat_end;
            e.addr  = cur;
            e.bytes = 13'(end_b - cur);
            e.len   = 8'((end_b - 1) / BEAT - cur / BEAT);
            e.last  = (end_b == stop);
            stage_q.push_back(e);
            cur = end_b;
        end
    endfunction

    function automatic void stage(input logic [63:0] a, input logic [7:0] l,
                                  input logic [12:0] b, input logic last);
        burst_t e;
        e.addr = a; e.len = l; e.bytes = b; e.last = last;
        stage_q.push_back(e);
    endfunction

    // Environment-side drivers: readies, done_ready and legal r_last pulses.
    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            1: begin bus.ar_ready_i = 1'b1; bus.txn_ready_i = 1'b1; end
            2: begin bus.ar_ready_i = 1'b1; bus.txn_ready_i = 1'b0; end
            default: begin
                bus.ar_ready_i  = ($urandom_range(0, 3) != 0);
                bus.txn_ready_i = ($urandom_range(0, 3) != 0);
            end
        endcase
        bus.r_last_i     = rst_n && rlast_en && (model_out > 0) && ($urandom_range(0, 2) == 0);
        bus.done_ready_i = ($urandom_range(0, 1) == 1);
    end

    // Monitor / scoreboard.
    bit          exp_v, fire_now;
    bit          prev_v, prev_fire;
    burst_t      prev_p, got;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ar_valid", bus.ar_valid_o, 0);
            chk("rst_txn_valid", bus.txn_valid_o, 0);
            chk("rst_done_valid", bus.done_valid_o, 0);
            chk("rst_req_ready", bus.req_ready_o, 1);
            prev_v = 1'b0;
            prev_fire = 1'b0;
        end else begin
            exp_v = (exp_q.size() != 0) && (model_out < MAX_OUT);
            chk("ar_valid", bus.ar_valid_o, exp_v);
            chk("txn_valid", bus.txn_valid_o, exp_v);
            chk("req_ready", bus.req_ready_o, tokens == 0);
            if (prev_v && !prev_fire && bus.ar_valid_o) begin
                chk("hold_ar_addr", bus.ar_addr_o, prev_p.addr);
                chk("hold_ar_len", bus.ar_len_o, prev_p.len);
                chk("hold_txn_bytes", bus.txn_bytes_o, prev_p.bytes);
                chk("hold_txn_last", bus.txn_last_o, prev_p.last);
            end
            fire_now = bus.ar_valid_o && bus.ar_ready_i && bus.txn_ready_i;
            if (fire_now) begin
                fire_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ar", exp_q.size(), 1);
                end else begin
                    got = exp_q.pop_front();
                    chk("ar_addr", bus.ar_addr_o, got.addr);
                    chk("txn_addr", bus.txn_addr_o, got.addr);
                    chk("ar_len", bus.ar_len_o, got.len);
                    chk("ar_size", bus.ar_size_o, SIZE);
                    chk("txn_bytes", bus.txn_bytes_o, got.bytes);
                    chk("txn_last", bus.txn_last_o, got.last);
                end
            end
            if (bus.done_valid_o) begin
                chk("done_pending_bursts", exp_q.size(), 0);
                chk("done_outstanding", model_out, 0);
                chk("done_token", tokens != 0, 1);
                if (bus.done_ready_i && tokens != 0) tokens--;
            end
            model_out = model_out + int'(fire_now) - int'(bus.r_last_i);
            prev_v    = bus.ar_valid_o;
            prev_fire = fire_now;
            prev_p.addr  = bus.ar_addr_o;
            prev_p.len   = bus.ar_len_o;
            prev_p.bytes = bus.txn_bytes_o;
            prev_p.last  = bus.txn_last_o;
        end
    end

    task automatic apply_reset(input int cycles);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        stage_q.delete();
        tokens = 0;
        model_out = 0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Presents the request while the DUT is idle; it is accepted on the next edge.
    task automatic send_req(input logic [63:0] a, input logic [31:0] n);
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        bus.req_bytes_i = n;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        while (stage_q.size() != 0) exp_q.push_back(stage_q.pop_front());
        tokens++;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (tokens != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        chk("done_timeout", tokens, 0);
        chk("bursts_left", exp_q.size(), 0);
        if (tokens != 0) apply_reset(2);
    endtask

    initial begin
        int f0;
        logic [63:0] a;
        logic [31:0] n;
        bus.req_valid_i  = 1'b0;
        bus.req_addr_i   = '0;
        bus.req_bytes_i  = '0;
        bus.ar_ready_i   = 1'b0;
        bus.txn_ready_i  = 1'b0;
        bus.r_last_i     = 1'b0;
        bus.done_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single aligned burst.
        stage(64'h1000, 8'd1, 13'd64, 1'b1);
        send_req(64'h1000, 32'd64);
        wait_done(500);

        // Page crossing from an unaligned start.
        stage(64'h0FF0, 8'd0, 13'd16, 1'b0);
        stage(64'h1000, 8'd1, 13'd48, 1'b1);
        send_req(64'h0FF0, 32'd64);
        wait_done(500);

        // Four full pages.
        stage(64'h0000, 8'd127, 13'd4096, 1'b0);
        stage(64'h1000, 8'd127, 13'd4096, 1'b0);
        stage(64'h2000, 8'd127, 13'd4096, 1'b0);
        stage(64'h3000, 8'd127, 13'd4096, 1'b1);
        send_req(64'h0, 32'd16384);
        wait_done(1000);

        // Outstanding limit: no r_last, only two bursts may go.
        ready_mode = 1;
        rlast_en = 1'b0;
        stage(64'h0000, 8'd127, 13'd4096, 1'b0);
        stage(64'h1000, 8'd127, 13'd4096, 1'b0);
        stage(64'h2000, 8'd127, 13'd4096, 1'b1);
        f0 = fire_cnt;
        send_req(64'h0, 32'd12288);
        repeat (20) @(posedge clk);
        chk("maxout_fires", fire_cnt - f0, 2);
        rlast_en = 1'b1;
        ready_mode = 0;
        wait_done(1000);

        // Zero-byte request.
        send_req(64'h1234, 32'd0);
        @(negedge clk);
        chk("zero_done_valid", bus.done_valid_o, 1);
        chk("zero_no_ar", bus.ar_valid_o, 0);
        wait_done(200);

        // AR ready but load unit not ready: nothing may fire.
        ready_mode = 2;
        stage(64'h1000, 8'd1, 13'd64, 1'b1);
        f0 = fire_cnt;
        send_req(64'h1000, 32'd64);
        repeat (5) @(posedge clk);
        chk("half_ready_fires", fire_cnt - f0, 0);
        ready_mode = 0;
        wait_done(500);

        // Reset in the middle of a request abandons it.
        model_bursts(64'h0, 64'd16384);
        send_req(64'h0, 32'd16384);
        repeat (4) @(posedge clk);
        f0 = fire_cnt;
        apply_reset(2);
        repeat (10) @(posedge clk);
        chk("post_reset_fires", fire_cnt - f0, 0);

        // Randomized requests.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0:       a = {32'h0, $urandom};
                1:       a = {32'h0, $urandom & 32'hFFFF_F000} | 64'(4096 - $urandom_range(1, 64));
                default: a = {32'h0, $urandom & 32'hFFFF_FFE0};
            endcase
            case ($urandom_range(0, 7))
                0:             n = 32'd0;
                1, 2, 3, 4:    n = $urandom_range(1, 300);
                default:       n = $urandom_range(1, 20000);
            endcase
            model_bursts(a, 64'(n));
            send_req(a, n);
            wait_done(3000);
        end

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
